cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//  Instruction sequencer for the 8-bit accumulator CPU. It steps an 8-phase fetch/execute cycle
//  and decodes the 3-bit opcode from the instruction register into control strobes.
//  It also samples the ALU zero flag. The strobes drive the address mux, memory, IR, PC, accumulator and data bus.
//  It sits between the IR/ALU (inputs) and every load/enable in the datapath (outputs).
// PARAMETERS
//  OPC_W   3   opcode width; must equal width of `OPCODE_* constants
// PORTS
//  clk     in   1      system clock, all state updates on rising edge
//  rst     in   1      synchronous, active-high reset
//  opcode  in   OPC_W  IR opcode field, valid from phase IDLE(3) onward
//  zero    in   1      ALU is_zero (accumulator == 0), combinational
//  sel     out  1      address mux: 1 = PC, 0 = IR operand address
//  rd      out  1      memory read enable
//  ld_ir   out  1      load instruction register
//  inc_pc  out  1      increment program counter
//  ld_pc   out  1      load PC from IR operand (jump)
//  halt    out  1      CPU halted indication
//  data_e  out  1      drive accumulator onto data bus
//  ld_ac   out  1      load accumulator from ALU out
//  wr      out  1      memory write strobe
//  phase   out  3      current phase (debug/trace)
// BEHAVIOUR
//  - Clock and reset: one clock (clk). rst is synchronous and active-high.
//  - State: 3-bit phase counter plus a 1-bit halted flag. Both registered. Outputs are combinational from phase/halted/opcode/zero.
//  - Reset: phase=0 and halted=0 on the first edge with rst=1.
//    While rst=1, every strobe output is forced 0. Reset has priority over all other events, including mid-instruction.
//  - Phases advance 0->1->...->7->0, one per clock, while not halted. There are no stalls.
//  - ALUOP = opcode in {ADD, AND, XOR, LDA}.
//  - Strobes per phase (all others 0):
//    0 INST_ADDR   sel=1
//    1 INST_FETCH  sel=1 rd=1
//    2 INST_LOAD   sel=1 rd=1 ld_ir=1
//    3 IDLE        sel=1 rd=1 ld_ir=1
//    4 OP_ADDR     inc_pc=(opcode!=HLT); halt=(opcode==HLT)
//    5 OP_FETCH    rd=ALUOP
//    6 ALU_OP      rd=ALUOP; inc_pc=(SKZ & zero); ld_pc=JMP; data_e=STO
//    7 STORE       rd=ALUOP; ld_ac=ALUOP; ld_pc=JMP; data_e=STO; wr=STO
//  - The zero flag is used only in phase 6; it is ignored in all other phases.
//  - HLT: at the phase-4 edge with opcode==HLT, halted<=1 and phase holds at 4.
//    While halted: halt=1 and every other strobe is 0, including sel. Only rst clears halted.
//  - Opcode values outside the `OPCODE_* set cannot occur at 3 bits. Any undefined decode yields all strobes 0.
//  - Each instruction takes exactly 8 cycles. PC advances once per instruction, or twice for a taken SKZ.
// STRUCTURE
//  - Shared defines (src/defines.v): the existing `OPCODE_* constants, plus the new `PH_INST_ADDR..`PH_STORE (3'd0..3'd7).
//  - Sub-module cpu_ctrl_decode: pure combinational phase/opcode/zero/halted -> strobe table.
//    The top holds only the phase counter, the halted flag and the reset forcing.
// TESTING
//  1. rst 1 cycle, then opcode=ADD, zero=0:
//     rd=1 in phases 1,2,3,5,6,7; ld_ir in 2,3; inc_pc only in 4; ld_ac only in 7; wr/ld_pc never.
//  2. opcode=STO: data_e=1 in phases 6,7; wr=1 in 7 only; rd=0 in 5..7; ld_ac=0 throughout.
//  3. opcode=SKZ, zero=1 in phase 6 -> inc_pc=1 in phases 4 and 6.
//     Repeat with zero=0 -> inc_pc in phase 4 only. zero toggling in other phases has no effect.
//  4. opcode=JMP: ld_pc=1 in phases 6,7; inc_pc=1 in 4; rd/wr/ld_ac=0 in 5..7.
//  5. opcode=HLT: halt=1 in phase 4. For the next 10 cycles phase=4, halt=1, all other strobes 0.
//     Then rst -> phase=0, halted=0; next cycle phase=0 with sel=1 only.
//  6. opcode=LDA, assert rst during phase 5: the next cycle shows phase=0 and all strobes 0.
//     After release, the full 8-phase sequence restarts from INST_ADDR.

Source files
------------

// File: rtl/cpu_controller_pkg.sv
// Shared opcode, phase and strobe definitions for the accumulator CPU sequencer.
package cpu_controller_pkg;

  localparam int OPC_W_DEF = 3;

  localparam logic [OPC_W_DEF-1:0] OP_HLT = 3'd0;
  localparam logic [OPC_W_DEF-1:0] OP_SKZ = 3'd1;
  localparam logic [OPC_W_DEF-1:0] OP_ADD = 3'd2;
  localparam logic [OPC_W_DEF-1:0] OP_AND = 3'd3;
  localparam logic [OPC_W_DEF-1:0] OP_XOR = 3'd4;
  localparam logic [OPC_W_DEF-1:0] OP_LDA = 3'd5;
  localparam logic [OPC_W_DEF-1:0] OP_STO = 3'd6;
  localparam logic [OPC_W_DEF-1:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_t;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic ld_pc;
    logic halt;
    logic data_e;
    logic ld_ac;
    logic wr;
  } strobes_t;

  // Opcodes that read an operand from memory and write the result to the accumulator.
  function automatic logic is_aluop(input logic [OPC_W_DEF-1:0] op);
    case (op)
      OP_ADD, OP_AND, OP_XOR, OP_LDA: is_aluop = 1'b1;
      default:                        is_aluop = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational strobe table: phase/opcode/zero/halted -> datapath control strobes.
module cpu_ctrl_decode
  import cpu_controller_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF
) (
  input  phase_t           phase,
  input  logic             halted,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output strobes_t         strobes
);

  logic aluop;
  logic op_hlt, op_skz, op_sto, op_jmp;

  assign aluop  = is_aluop(opcode);
  assign op_hlt = (opcode == OP_HLT);
  assign op_skz = (opcode == OP_SKZ);
  assign op_sto = (opcode == OP_STO);
  assign op_jmp = (opcode == OP_JMP);

  always_comb begin
    // NOTE: default every output first so no path through the case leaves a latch.
    strobes = '0;
    if (halted) begin
      strobes.halt = 1'b1;
    end else begin
      case (phase)
        PH_INST_ADDR: strobes.sel = 1'b1;
        PH_INST_FETCH: begin
          strobes.sel = 1'b1;
          strobes.rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          strobes.sel   = 1'b1;
          strobes.rd    = 1'b1;
          strobes.ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          strobes.inc_pc = !op_hlt;
          strobes.halt   = op_hlt;
        end
        PH_OP_FETCH: strobes.rd = aluop;
        PH_ALU_OP: begin
          // zero only matters here: a taken SKZ bumps the PC a second time.
          strobes.rd     = aluop;
          strobes.inc_pc = op_skz & zero;
          strobes.ld_pc  = op_jmp;
          strobes.data_e = op_sto;
        end
        PH_STORE: begin
          strobes.rd     = aluop;
          strobes.ld_ac  = aluop;
          strobes.ld_pc  = op_jmp;
          strobes.data_e = op_sto;
          strobes.wr     = op_sto;
        end
        default: strobes = '0;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer: phase counter, halted flag and reset forcing of strobes.
module cpu_controller
  import cpu_controller_pkg::*;
#(
  parameter int OPC_W = OPC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             halt,
  output logic             data_e,
  output logic             ld_ac,
  output logic             wr,
  output logic [2:0]       phase
);

  phase_t   phase_q;
  logic     halted_q;
  strobes_t strobes;
  strobes_t strobes_out;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
        halted_q <= 1'b1;
      end else begin
        phase_q <= phase_t'(phase_q + 3'd1);
      end
    end
  end

  cpu_ctrl_decode #(.OPC_W(OPC_W)) u_decode (
    .phase   (phase_q),
    .halted  (halted_q),
    .opcode  (opcode),
    .zero    (zero),
    .strobes (strobes)
  );

  // Reset wins over everything, including a half-finished instruction.
  assign strobes_out = rst ? '0 : strobes;

  assign sel    = strobes_out.sel;
  assign rd     = strobes_out.rd;
  assign ld_ir  = strobes_out.ld_ir;
  assign inc_pc = strobes_out.inc_pc;
  assign ld_pc  = strobes_out.ld_pc;
  assign halt   = strobes_out.halt;
  assign data_e = strobes_out.data_e;
  assign ld_ac  = strobes_out.ld_ac;
  assign wr     = strobes_out.wr;
  assign phase  = phase_q;

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench: directed instruction walks plus randomized traffic against a rule-level model.
module tb_cpu_controller;
  import cpu_controller_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr;
  logic [2:0] phase;

  int errors = 0;
  int checks = 0;

  int   ph_m     = 0;
  bit   halted_m = 1'b0;
  bit   check_en = 1'b0;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .halt   (halt),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .phase  (phase)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,halt,data_e,ld_ac,wr}, written as rules per strobe.
  function automatic logic [8:0] expect_strobes(input bit r, input int ph, input bit hlt,
                                                input logic [2:0] op, input bit z);
    bit alu;
    logic [8:0] e;
    alu = (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    if (r) return 9'd0;
    if (hlt) return 9'b0_0000_1000;
    e[8] = (ph <= 3);
    e[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
    e[6] = (ph == 2 || ph == 3);
    e[5] = (ph == 4 && op != OP_HLT) || (ph == 6 && op == OP_SKZ && z);
    e[4] = (ph >= 6 && op == OP_JMP);
    e[3] = (ph == 4 && op == OP_HLT);
    e[2] = (ph >= 6 && op == OP_STO);
    e[1] = (ph == 7 && alu);
    e[0] = (ph == 7 && op == OP_STO);
    return e;
  endfunction

  // Model state: advances one phase per clock unless halted; reset returns to phase 0.
  always @(posedge clk) begin
    check_en <= 1'b1;
    if (rst) begin
      ph_m     <= 0;
      halted_m <= 1'b0;
    end else if (!halted_m) begin
      if (ph_m == 4 && opcode == OP_HLT) halted_m <= 1'b1;
      else ph_m <= (ph_m + 1) % 8;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("phase", 32'(phase), 32'(ph_m));
      check("strobes", 32'({sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}),
            32'(expect_strobes(rst, ph_m, halted_m, opcode, zero)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk one full instruction from phase 0, recording per-phase strobe bitmaps (bit i = phase i).
  task automatic run_map(input logic [2:0] op, input bit z6, input bit z_rand,
                         output logic [7:0] m_rd, output logic [7:0] m_ld_ir,
                         output logic [7:0] m_inc, output logic [7:0] m_ldpc,
                         output logic [7:0] m_de, output logic [7:0] m_ldac,
                         output logic [7:0] m_wr);
    opcode = op;
    for (int i = 0; i < 8; i++) begin
      zero = (i == 6) ? z6 : (z_rand ? 1'($urandom_range(0, 1)) : 1'b0);
      @(negedge clk);
      m_rd[i] = rd;  m_ld_ir[i] = ld_ir; m_inc[i] = inc_pc; m_ldpc[i] = ld_pc;
      m_de[i] = data_e; m_ldac[i] = ld_ac; m_wr[i] = wr;
      step();
    end
  endtask

  logic [7:0] m_rd, m_ld_ir, m_inc, m_ldpc, m_de, m_ldac, m_wr;

  initial begin
    rst = 1'b1; opcode = OP_ADD; zero = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("reset_phase", 32'(phase), 32'd0);
    check("reset_sel_only", 32'({sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}), 32'h100);
    step();
    // Phase 1 of a stray instruction has started; finish it so the walks start at phase 0.
    for (int i = 1; i < 8; i++) step();

    run_map(OP_ADD, 1'b0, 1'b0, m_rd, m_ld_ir, m_inc, m_ldpc, m_de, m_ldac, m_wr);
    check("add_rd", 32'(m_rd), 32'h0EE);
    check("add_ld_ir", 32'(m_ld_ir), 32'h0C);
    check("add_inc_pc", 32'(m_inc), 32'h10);
    check("add_ld_ac", 32'(m_ldac), 32'h80);
    check("add_wr_ld_pc", 32'({m_wr, m_ldpc}), 32'h0);

    run_map(OP_STO, 1'b1, 1'b1, m_rd, m_ld_ir, m_inc, m_ldpc, m_de, m_ldac, m_wr);
    check("sto_data_e", 32'(m_de), 32'hC0);
    check("sto_wr", 32'(m_wr), 32'h80);
    check("sto_rd", 32'(m_rd), 32'h0E);
    check("sto_ld_ac", 32'(m_ldac), 32'h0);

    run_map(OP_SKZ, 1'b1, 1'b1, m_rd, m_ld_ir, m_inc, m_ldpc, m_de, m_ldac, m_wr);
    check("skz_taken_inc_pc", 32'(m_inc), 32'h50);
    run_map(OP_SKZ, 1'b0, 1'b1, m_rd, m_ld_ir, m_inc, m_ldpc, m_de, m_ldac, m_wr);
    check("skz_not_taken_inc_pc", 32'(m_inc), 32'h10);

    run_map(OP_JMP, 1'b1, 1'b1, m_rd, m_ld_ir, m_inc, m_ldpc, m_de, m_ldac, m_wr);
    check("jmp_ld_pc", 32'(m_ldpc), 32'hC0);
    check("jmp_inc_pc", 32'(m_inc), 32'h10);
    check("jmp_rd_wr_ld_ac", 32'({m_rd[7:5], m_wr[7:5], m_ldac[7:5]}), 32'h0);

    opcode = OP_HLT;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) check("hlt_phase4_halt", 32'({inc_pc, halt}), 32'b01);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      zero = 1'($urandom_range(0, 1));
      opcode = 3'($urandom_range(0, 7));
      @(negedge clk);
      check("halted_phase", 32'(phase), 32'd4);
      check("halted_strobes", 32'({sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}), 32'h008);
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    check("hlt_rst_strobes", 32'({sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}), 32'h0);
    step();
    rst = 1'b0; opcode = OP_LDA;
    @(negedge clk);
    check("post_hlt_phase", 32'(phase), 32'd0);
    check("post_hlt_sel_only", 32'({sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}), 32'h100);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("lda_rst_phase", 32'(phase), 32'd0);
    check("lda_rst_strobes", 32'({sel, rd, ld_ir, inc_pc, ld_pc, halt, data_e, ld_ac, wr}), 32'h0);
    step();
    rst = 1'b0;
    run_map(OP_LDA, 1'b1, 1'b1, m_rd, m_ld_ir, m_inc, m_ldpc, m_de, m_ldac, m_wr);
    check("lda_rd", 32'(m_rd), 32'h0EE);
    check("lda_ld_ac", 32'(m_ldac), 32'h80);

    // Random traffic: a new opcode at each instruction start, random zero, occasional reset.
    for (int n = 0; n < 3000; n++) begin
      if (ph_m == 0) opcode = 3'($urandom_range(0, 7));
      zero = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 63) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
